// File: rtl/mul16_seq.sv
// mul16_seq -- sequential 16x16 shift-and-add multiplier built around a
// single 16-bit ripple adder (add16). One partial product is accumulated
// per cycle, so a result appears 16 cycles after an accepted start.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request; only sampled while the unit is not busy
//   a, b     16-bit multiplicand / multiplier, captured on an accepted start
//   busy     high while the 16 iterations are running
//   done     one-cycle pulse, product has just been updated
//   product  32-bit result of the last completed operation (held)
//
// Build option:
//   MUL16_SIGNED_EN  when defined, operands and product are two's-complement.
//                    Magnitudes are multiplied and the sign is applied at the
//                    end, so latency and handshake are identical.

// 16-bit ripple-carry adder
module add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [16:0] carry;

  assign carry[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_bit
      assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = carry[16];
endmodule

module mul16_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_reg;
  logic [15:0] mcand_reg;
  logic [15:0] mplier_reg;
  logic [15:0] acc_reg;
  logic [4:0]  cnt_reg;
  logic        busy_reg;
  logic        done_reg;
  logic [31:0] product_reg;

  logic [15:0] add_b;
  logic [15:0] add_sum;
  logic        add_cout;
  logic [31:0] shift_next;    // {acc, mplier} after this iteration's shift
  logic [31:0] product_next;
  logic [15:0] mcand_load;
  logic [15:0] mplier_load;

  // Partial product is either the multiplicand or zero, selected by the
  // multiplier LSB; cin is unused.
  assign add_b = mplier_reg[0] ? mcand_reg : 16'h0000;

  add16 u_add16 (
    .a    (acc_reg),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Carry-out becomes the new accumulator MSB; the adder LSB moves into the
  // top of the multiplier register as the consumed multiplier bit drops out.
  assign shift_next = {add_cout, add_sum, mplier_reg[15:1]};

`ifdef MUL16_SIGNED_EN
  logic sign_reg;

  // Magnitudes; 16'h8000 negates to itself, which is the correct unsigned
  // magnitude.
  assign mcand_load   = a[15] ? (~a + 16'd1) : a;
  assign mplier_load  = b[15] ? (~b + 16'd1) : b;
  assign product_next = sign_reg ? (~shift_next + 32'd1) : shift_next;
`else
  assign mcand_load   = a;
  assign mplier_load  = b;
  assign product_next = shift_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      mcand_reg   <= 16'h0000;
      mplier_reg  <= 16'h0000;
      acc_reg     <= 16'h0000;
      cnt_reg     <= 5'd0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      product_reg <= 32'h0000_0000;
`ifdef MUL16_SIGNED_EN
      sign_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (start) begin
            mcand_reg  <= mcand_load;
            mplier_reg <= mplier_load;
            acc_reg    <= 16'h0000;
            cnt_reg    <= 5'd0;
            busy_reg   <= 1'b1;
            state_reg  <= RUN;
`ifdef MUL16_SIGNED_EN
            sign_reg   <= a[15] ^ b[15];
`endif
          end else begin
            state_reg <= IDLE;
          end
        end

        RUN: begin
          // start is deliberately ignored here
          acc_reg    <= shift_next[31:16];
          mplier_reg <= shift_next[15:0];
          cnt_reg    <= cnt_reg + 5'd1;
          if (cnt_reg == 5'd15) begin
            product_reg <= product_next;
            done_reg    <= 1'b1;
            busy_reg    <= 1'b0;
            state_reg   <= DONE;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign product = product_reg;
endmodule

// File: tb/tb_mul16_seq.sv
// Directed testbench for mul16_seq. Inputs are driven and outputs sampled on
// the falling clock edge. Vectors for the signed build are selected with the
// same MUL16_SIGNED_EN macro as the design.
module tb_mul16_seq;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int n_cmp;
  int n_err;

  mul16_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one start, wait (bounded) for done; returns latency in cycles
  // counted from the accepting edge, and the product seen with done.
  task automatic run_op(input logic [15:0] va, input logic [15:0] vb,
                        output int lat, output logic [31:0] prod);
    @(negedge clk);
    start = 1'b1; a = va; b = vb;
    @(negedge clk);
    start = 1'b0; a = 16'hxxxx; b = 16'hxxxx;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_after_start got=%b exp=1", busy);
    end
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy === 1'b1 && done === 1'b1) begin
        n_cmp++; n_err++;
        $display("FAIL busy_done_overlap busy=%b done=%b exp not both", busy, done);
      end
    end
    prod = product;
    $display("op a=%h b=%h product=%h latency=%0d", va, vb, prod, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = 16'h0; b = 16'h0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state got busy=%b done=%b product=%h exp 0/0/00000000",
               busy, done, product);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset released busy=%b done=%b product=%h", busy, done, product);
  endtask

  task automatic test_basic();
    int lat;
    logic [31:0] p;
`ifdef MUL16_SIGNED_EN
    run_op(16'h0007, 16'hFFFD, lat, p);
    n_cmp++;
    if (p !== 32'hFFFF_FFEB) begin
      n_err++; $display("FAIL basic_product got=%h exp=FFFFFFEB", p);
    end
`else
    run_op(16'h0003, 16'h0005, lat, p);
    n_cmp++;
    if (p !== 32'h0000_000F) begin
      n_err++; $display("FAIL basic_product got=%h exp=0000000F", p);
    end
`endif
    n_cmp++;
    if (lat !== 16) begin
      n_err++; $display("FAIL basic_latency got=%0d exp=16", lat);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL basic_busy_at_done got=%b exp=0", busy);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL basic_done_pulse_width got=%b exp=0", done);
    end
  endtask

  task automatic test_vectors();
    logic [15:0] va [5];
    logic [15:0] vb [5];
    logic [31:0] vp [5];
    int lat;
    logic [31:0] p;
`ifdef MUL16_SIGNED_EN
    va = '{16'hFFFF, 16'h8000, 16'h8000, 16'h0007, 16'h0003};
    vb = '{16'hFFFF, 16'h8000, 16'h0001, 16'hFFFD, 16'h0005};
    vp = '{32'h0000_0001, 32'h4000_0000, 32'hFFFF_8000, 32'hFFFF_FFEB, 32'h0000_000F};
`else
    va = '{16'hFFFF, 16'h0000, 16'h1234, 16'h8000, 16'h00FF};
    vb = '{16'hFFFF, 16'h1234, 16'h5678, 16'h0002, 16'h0101};
    vp = '{32'hFFFE_0001, 32'h0000_0000, 32'h0626_0060, 32'h0001_0000, 32'h0000_FFFF};
`endif
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], lat, p);
      n_cmp++;
      if (p !== vp[i]) begin
        n_err++;
        $display("FAIL vector%0d_product got=%h exp=%h", i, p, vp[i]);
      end
      n_cmp++;
      if (lat !== 16) begin
        n_err++;
        $display("FAIL vector%0d_latency got=%0d exp=16", i, lat);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    int extra_done;
    @(negedge clk);
    start = 1'b1; a = 16'h1234; b = 16'h5678;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    extra_done = 0;
    // Second request lands on the 5th RUN edge and must be ignored
    while (done !== 1'b1 && lat < 40) begin
      if (lat == 4) begin
        start = 1'b1; a = 16'h0002; b = 16'h0002;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    $display("op ignore_start product=%h latency=%0d", product, lat);
    n_cmp++;
`ifdef MUL16_SIGNED_EN
    if (product !== 32'h0626_0060) begin
      n_err++; $display("FAIL ignore_product got=%h exp=06260060", product);
    end
`else
    if (product !== 32'h0626_0060) begin
      n_err++; $display("FAIL ignore_product got=%h exp=06260060", product);
    end
`endif
    n_cmp++;
    if (lat !== 16) begin
      n_err++; $display("FAIL ignore_latency got=%0d exp=16", lat);
    end
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra_done++;
    end
    n_cmp++;
    if (extra_done !== 0) begin
      n_err++; $display("FAIL ignore_extra_activity got=%0d cycles exp=0", extra_done);
    end
  endtask

  task automatic test_back_to_back();
    int lat1;
    int lat2;
    logic [31:0] p;
    run_op(16'h0007, 16'h0009, lat1, p);
    n_cmp++;
    if (p !== 32'h0000_003F) begin
      n_err++; $display("FAIL b2b_first_product got=%h exp=0000003F", p);
    end
    // Still in the DONE cycle: request again
    start = 1'b1; a = 16'h0002; b = 16'h0003;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || product !== 32'h0000_003F) begin
      n_err++;
      $display("FAIL b2b_accept got busy=%b done=%b product=%h exp 1/0/0000003F",
               busy, done, product);
    end
    lat2 = 1;
    while (done !== 1'b1 && lat2 < 40) begin
      @(negedge clk);
      lat2++;
    end
    $display("op b2b a=0002 b=0003 product=%h done_gap=%0d", product, lat2);
    n_cmp++;
    if (lat2 !== 17) begin
      n_err++; $display("FAIL b2b_done_gap got=%0d exp=17", lat2);
    end
    n_cmp++;
    if (product !== 32'h0000_0006) begin
      n_err++; $display("FAIL b2b_second_product got=%h exp=00000006", product);
    end
  endtask

  task automatic test_abort_reset();
    int lat;
    int seen;
    logic [31:0] p;
    @(negedge clk);
    start = 1'b1; a = 16'h0100; b = 16'h0100;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0) begin
      n_err++;
      $display("FAIL abort_state got busy=%b done=%b product=%h exp 0/0/00000000",
               busy, done, product);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++; $display("FAIL abort_late_done got=%0d pulses exp=0", seen);
    end
    $display("abort: reset mid-run, product=%h", product);
    run_op(16'h00FF, 16'h0101, lat, p);
    n_cmp++;
    if (p !== 32'h0000_FFFF || lat !== 16) begin
      n_err++;
      $display("FAIL abort_restart got product=%h lat=%0d exp 0000FFFF/16", p, lat);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_vectors();
    test_ignore_start();
    test_back_to_back();
    test_abort_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mul16_seq.md
# mul16_seq

Sequential 16×16 shift-and-add multiplier that sits directly downstream of `add16` and consumes its `sum`/`cout` once per cycle. One `add16` instance accumulates partial products over 16 iterations, so a single 16-bit adder produces a full 32-bit product. A start/busy/done handshake makes it usable as a multi-cycle functional unit next to the ALU.

## Interface
- No parameters. The datapath width is fixed at 16 to match `add16`.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request; sampled on a rising edge only when the unit is not busy
- `a`  in  16  multiplicand, captured on an accepted start
- `b`  in  16  multiplier, captured on an accepted start
- `busy`  out  1  high while an operation is in progress
- `done`  out  1  one-cycle pulse: `product` has just been updated
- `product`  out  32  result of the last completed operation; held until the next completion

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: performs 16 iterations.
  - DONE: single cycle in which `done` is high.
- IDLE/DONE with `start`=1 at an edge:
  - capture `a` into `mcand` (16b) and `b` into `mplier` (16b)
  - clear `acc` (16b) and the iteration counter (5b)
  - go to RUN
- DONE with `start`=0: return to IDLE.
- RUN, every cycle:
  - `add16` inputs: a=`acc`, b=`mplier[0]` ? `mcand` : 16'h0000, `cin` tied to 0.
  - Register update: {`acc`,`mplier`} ← {`cout`,`sum`,`mplier`[15:1]}, a 33-bit right shift.
  - The counter increments. After the 16th iteration, `product` ← {`acc`,`mplier`} (post-update) and the state goes to DONE.
- `start` while in RUN is ignored: no capture and no effect on the operation in progress.
- The input registers are internal, so `a`/`b` may change freely after the start edge.
- `product` is a separate holding register and never shows intermediate values.
- Arithmetic is unsigned modulo 2^32. The full product always fits, so there is no overflow flag.

## Timing
- Reset values:
  - state IDLE
  - `busy`=0, `done`=0, `product`=32'h0
  - `acc`, `mplier`, `mcand` and the counter all 0
- Reset is asynchronous. Asserting `rst_n` mid-operation aborts immediately with no `done` pulse, and `product` returns to 0.
- Start sampled at edge E0:
  - `busy`=1 from E0 to E16.
  - At E16, `product` is updated, `done`=1 for the cycle E16–E17, and `busy`=0.
- Latency is 16 cycles from start to `done`, independent of operand values. There is no early exit.
- Back-to-back operation: `start`=1 during the DONE cycle is accepted at E17. `busy` rises again, and the next `done` comes at E33. Throughput is one result per 17 cycles.
- `done` and `busy` are never high together.
- Critical path: one `add16` ripple chain plus the 2:1 mux on its b input.

## Configuration
- `MUL16_SIGNED_EN` undefined: operands and product are unsigned, as described above.
- `MUL16_SIGNED_EN` defined: operands and product are two's-complement.
  - At start capture: `mcand`=|a|, `mplier`=|b|, and sign = a[15]^b[15] is stored. 16'h8000 maps to magnitude 16'h8000, which is valid as unsigned.
  - At completion: `product` = sign ? (~P + 1) : P, where P is the 32-bit magnitude product.
  - Latency and handshake are unchanged.

## Test plan
- Unsigned build, a=0003, b=0005, single start pulse → `done` exactly 16 cycles after the start edge, `product`=0000000F, `busy` low in the same cycle `done` rises.
- Unsigned build, a=FFFF, b=FFFF → `product`=FFFE0001. Then a=0000, b=1234 → `product`=00000000. Then a=1234, b=5678 → `product`=06260060.
- `start` pulsed again at cycle 5 of RUN with different operands → ignored. The first result is delivered unchanged at cycle 16, and only one `done` pulse occurs.
- `start` held high through the DONE cycle with a=0002, b=0003 → second operation accepted, second `done` 17 cycles after the first, `product`=00000006.
- `rst_n` pulsed low at cycle 8 of RUN → immediately `busy`=0, `done`=0, `product`=0. No `done` follows, and a new start completes normally.
- Build with `MUL16_SIGNED_EN`:
  - FFFF×FFFF → 00000001
  - 8000×8000 → 40000000
  - 8000×0001 → FFFF8000
  - 0007×FFFD → FFFFFFEB
  - Latency stays 16 cycles.
